mc_de_pcq: RTL

MC_DE_PCQ -- requirements
Module: mc_de_pcq

---
 rtl/mc_de_pcq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mc_de_pcq.sv
// Drawing-engine page command queue.
// A request splitter breaks each (addr, len) request into chunks of up to 16 words.
// The chunks go into a circular command queue. Its head entry is presented show-ahead.
module mc_de_pcq #(
  parameter int DEPTH = 8
) (
  input  logic        mclock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [6:0]  req_len,
  input  logic        req_read,
  input  logic        req_rmw,
  input  logic        req_line,
  input  logic        de_pc_pop,
  output logic        de_pc_empty,
  output logic [31:0] de_address,
  output logic [3:0]  de_page,
  output logic        de_read,
  output logic        de_rmw,
  output logic        line_actv_4,
  output logic [4:0]  pc_level,
  output logic        pc_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, SPLIT} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  page;
    logic        rd;
    logic        rmw;
    logic        line;
  } entry_t;

  entry_t mem [DEPTH];

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [6:0]    rem_q, rem_d;
  logic          rd_q, rd_d, rmw_q, rmw_d, line_q, line_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          err_q, err_d;

  logic          full, empty, push, pop_ok, last_chunk;
  logic [3:0]    chunk_page;
  entry_t        push_entry, head;

  // Queue status and the chunk the splitter would push this cycle.
  always_comb begin
    full       = (count_q == 5'(DEPTH));
    empty      = (count_q == 5'd0);
    push       = (state_q == SPLIT) && !full;
    pop_ok     = de_pc_pop && !empty;
    last_chunk = (rem_q <= 7'd15);
    chunk_page = last_chunk ? rem_q[3:0] : 4'd15;
    push_entry = '{addr: addr_q, page: chunk_page, rd: rd_q, rmw: rmw_q, line: line_q};
  end

  // Next-state logic for the splitter, the queue pointers, the count and the error flag.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    rd_d     = rd_q;
    rmw_d    = rmw_q;
    line_d   = line_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    err_d    = err_q;

    if (state_q == IDLE) begin
      if (req_valid) begin
        addr_d  = req_addr;
        rem_d   = req_len;
        rd_d    = req_read;
        rmw_d   = req_rmw;
        line_d  = req_line;
        state_d = SPLIT;
      end
    end else if (push) begin
      // The address wraps modulo 2^32 by construction.
      addr_d   = addr_q + 32'(chunk_page) + 32'd1;
      // Once the last chunk is out, rem is no longer used, so it may wrap here.
      rem_d    = rem_q - 7'd16;
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (last_chunk) state_d = IDLE;
    end

    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (de_pc_pop && empty) err_d = 1'b1;

    count_d = count_q + 5'(push) - 5'(pop_ok);
  end

  // Control registers. A reset discards any partial request and all queued entries.
  always_ff @(posedge mclock) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      rd_q     <= 1'b0;
      rmw_q    <= 1'b0;
      line_q   <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      rd_q     <= rd_d;
      rmw_q    <= rmw_d;
      line_q   <= line_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Entry storage. It is not reset, because the count alone decides which entries are valid.
  always_ff @(posedge mclock) begin
    if (push && !reset) mem[wr_ptr_q] <= push_entry;
  end

  // Show-ahead head outputs. When the queue is empty they show a stale entry.
  always_comb begin
    head        = mem[rd_ptr_q];
    de_address  = head.addr;
    de_page     = head.page;
    de_read     = head.rd;
    de_rmw      = head.rmw;
    line_actv_4 = head.line;
    req_ready   = (state_q == IDLE);
    de_pc_empty = empty;
    pc_level    = count_q;
    pc_err      = err_q;
  end

endmodule
